// File: rtl/countdown_display_core_if.sv
// Command/status bundle between the stopwatch controller and the countdown core.
// The core takes the slave view; the controller (or a bench) the master view.
interface countdown_display_core_if;
    logic [7:0] sw_val;
    logic       load_sec;
    logic       load_min;
    logic       clear;
    logic       run;
    logic       flash;
    logic       zero;
    logic       done;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;

    modport master (
        output sw_val, load_sec, load_min, clear, run, flash,
        input  zero, done, HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  sw_val, load_sec, load_min, clear, run, flash,
        output zero, done, HEX0, HEX1, HEX2, HEX3
    );
endinterface

// File: rtl/countdown_display_core.sv
// MM:SS BCD countdown timer with 1 Hz prescaler, clamped loads,
// registered seven-segment outputs and a blanking flash mode.
module countdown_display_core #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int BLINK_TICKS   = 25000000
) (
    input logic                     CLOCK_50,
    input logic                     reset,
    countdown_display_core_if.slave bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    logic [3:0]    mt_q, mt_d, mo_q, mo_d;
    logic [3:0]    st_q, st_d, so_q, so_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          phase_q, phase_d;
    logic          hit_q, hit_d;
    logic          zero_q, zero_d;
    logic          done_q, done_d;
    logic [6:0]    hex0_q, hex0_d, hex1_q, hex1_d;
    logic [6:0]    hex2_q, hex2_d, hex3_q, hex3_d;

    logic tick;
    logic nonzero;
    logic blank;

    function automatic logic [3:0] clamp(input logic [3:0] v,
                                         input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        psc_d   = psc_q;
        hit_d   = 1'b0;
        nonzero = |{mt_q, mo_q, st_q, so_q};
        tick    = bus.run && (psc_q == PSC_MAX);

        if (bus.clear) begin
            mt_d  = 4'd0;
            mo_d  = 4'd0;
            st_d  = 4'd0;
            so_d  = 4'd0;
            psc_d = '0;
        end else if (bus.load_sec || bus.load_min) begin
            if (bus.load_sec) begin
                st_d = clamp(bus.sw_val[7:4], 4'd5);
                so_d = clamp(bus.sw_val[3:0], 4'd9);
            end
            if (bus.load_min) begin
                mt_d = clamp(bus.sw_val[7:4], 4'd9);
                mo_d = clamp(bus.sw_val[3:0], 4'd9);
            end
            psc_d = '0;
        end else if (bus.run) begin
            psc_d = tick ? '0 : psc_q + PW'(1);
            if (tick && nonzero) begin
                // Only 00:01 can decrement onto 00:00.
                hit_d = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                        (st_q == 4'd0) && (so_q == 4'd1);
                if (so_q != 4'd0) begin
                    so_d = so_q - 4'd1;
                end else begin
                    so_d = 4'd9;
                    if (st_q != 4'd0) begin
                        st_d = st_q - 4'd1;
                    end else begin
                        st_d = 4'd5;
                        if (mo_q != 4'd0) begin
                            mo_d = mo_q - 4'd1;
                        end else begin
                            mo_d = 4'd9;
                            mt_d = mt_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        blk_d   = '0;
        phase_d = 1'b0;
        if (bus.flash) begin
            if (blk_q == BLK_MAX) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d   = blk_q + BW'(1);
                phase_d = phase_q;
            end
        end
    end

    // Dropping flash un-blanks on the very next output update.
    always_comb begin
        blank  = bus.flash && phase_q;
        hex0_d = blank ? SEG_BLANK : seg7(so_q);
        hex1_d = blank ? SEG_BLANK : seg7(st_q);
        hex2_d = blank ? SEG_BLANK : seg7(mo_q);
        hex3_d = blank ? SEG_BLANK : seg7(mt_q);
        zero_d = ~|{mt_q, mo_q, st_q, so_q};
        done_d = hit_q;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            psc_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            hit_q   <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            hex0_q  <= SEG_ZERO;
            hex1_q  <= SEG_ZERO;
            hex2_q  <= SEG_ZERO;
            hex3_q  <= SEG_ZERO;
        end else begin
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            psc_q   <= psc_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            hit_q   <= hit_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
            hex3_q  <= hex3_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.done = done_q;
    assign bus.HEX0 = hex0_q;
    assign bus.HEX1 = hex1_q;
    assign bus.HEX2 = hex2_q;
    assign bus.HEX3 = hex3_q;

endmodule

// File: tb/tb_countdown_display_core.sv
// Directed bench for countdown_display_core with a 4-cycle second
// and a 3-cycle flash phase.
module tb_countdown_display_core;

    localparam logic [6:0] D0 = 7'h40;
    localparam logic [6:0] D1 = 7'h79;
    localparam logic [6:0] D2 = 7'h24;
    localparam logic [6:0] D4 = 7'h19;
    localparam logic [6:0] D5 = 7'h12;
    localparam logic [6:0] D7 = 7'h78;
    localparam logic [6:0] D8 = 7'h00;
    localparam logic [6:0] D9 = 7'h10;
    localparam logic [6:0] BL = 7'h7F;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    countdown_display_core_if bus();

    countdown_display_core #(
        .TICKS_PER_SEC(4),
        .BLINK_TICKS  (3)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hx(input logic [6:0] h3,
                                       input logic [6:0] h2,
                                       input logic [6:0] h1,
                                       input logic [6:0] h0);
        return {4'h0, h3, h2, h1, h0};
    endfunction

    function automatic logic [31:0] disp();
        return {4'h0, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    endfunction

    task automatic lsec(input logic [7:0] v);
        bus.sw_val   = v;
        bus.load_sec = 1'b1;
        step(1);
        bus.load_sec = 1'b0;
    endtask

    task automatic lmin(input logic [7:0] v);
        bus.sw_val   = v;
        bus.load_min = 1'b1;
        step(1);
        bus.load_min = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.sw_val   = 8'h00;
        bus.load_sec = 1'b0;
        bus.load_min = 1'b0;
        bus.clear    = 1'b0;
        bus.run      = 1'b0;
        bus.flash    = 1'b0;
        step(2);
        chk("rst_hex", disp(), hx(D0, D0, D0, D0));
        chk("rst_zero", {31'b0, bus.zero}, 32'd1);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        rst_n = 1'b1;

        bus.run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_done", {31'b0, bus.done}, 32'd0);
        end
        chk("idle_zero", {31'b0, bus.zero}, 32'd1);
        chk("idle_hex", disp(), hx(D0, D0, D0, D0));
        bus.run = 1'b0;

        lmin(8'h01);
        lsec(8'h00);
        step(1);
        chk("ld_0100", disp(), hx(D0, D1, D0, D0));
        chk("ld_zero", {31'b0, bus.zero}, 32'd0);
        bus.run = 1'b1;
        step(4);
        bus.run = 1'b0;
        chk("pre_tick", disp(), hx(D0, D1, D0, D0));
        step(1);
        chk("tick_0059", disp(), hx(D0, D0, D5, D9));

        lmin(8'h00);
        lsec(8'h02);
        bus.run = 1'b1;
        step(4);
        chk("t1_done", {31'b0, bus.done}, 32'd0);
        step(1);
        chk("t1_hex", disp(), hx(D0, D0, D0, D1));
        step(3);
        chk("t2_done0", {31'b0, bus.done}, 32'd0);
        chk("t2_zero0", {31'b0, bus.zero}, 32'd0);
        step(1);
        chk("t2_done", {31'b0, bus.done}, 32'd1);
        chk("t2_zero", {31'b0, bus.zero}, 32'd1);
        chk("t2_hex", disp(), hx(D0, D0, D0, D0));
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_done", {31'b0, bus.done}, 32'd0);
        end
        chk("hold_zero", {31'b0, bus.zero}, 32'd1);
        bus.run = 1'b0;

        lsec(8'hFF);
        lmin(8'hAB);
        chk("clamp_sec", disp(), hx(D0, D0, D5, D9));
        step(1);
        chk("clamp_min", disp(), hx(D9, D9, D5, D9));
        lsec(8'h00);
        bus.run = 1'b1;
        step(4);
        bus.run = 1'b0;
        step(1);
        chk("dec_9859", disp(), hx(D9, D8, D5, D9));

        bus.sw_val   = 8'h7C;
        bus.load_sec = 1'b1;
        bus.load_min = 1'b1;
        step(1);
        bus.load_sec = 1'b0;
        bus.load_min = 1'b0;
        step(1);
        chk("both_7959", disp(), hx(D7, D9, D5, D9));

        lmin(8'h00);
        lsec(8'h10);
        bus.run = 1'b1;
        step(2);
        bus.run = 1'b0;
        step(10);
        chk("pause_hold", disp(), hx(D0, D0, D1, D0));
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
        step(1);
        chk("pause_3", disp(), hx(D0, D0, D1, D0));
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
        step(1);
        chk("pause_tick", disp(), hx(D0, D0, D0, D9));

        lsec(8'h10);
        bus.run = 1'b1;
        step(2);
        lsec(8'h10);
        step(3);
        bus.run = 1'b0;
        step(1);
        chk("ldrun_notick", disp(), hx(D0, D0, D1, D0));
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
        step(1);
        chk("ldrun_tick", disp(), hx(D0, D0, D0, D9));

        lsec(8'h01);
        bus.run = 1'b1;
        step(3);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        bus.run   = 1'b0;
        chk("clr_done0", {31'b0, bus.done}, 32'd0);
        step(1);
        chk("clr_done1", {31'b0, bus.done}, 32'd0);
        chk("clr_zero", {31'b0, bus.zero}, 32'd1);
        step(1);
        chk("clr_done2", {31'b0, bus.done}, 32'd0);

        lsec(8'h01);
        bus.run = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("arst_hex", disp(), hx(D0, D0, D0, D0));
        chk("arst_zero", {31'b0, bus.zero}, 32'd1);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        bus.run = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("arst_post", {31'b0, bus.done}, 32'd0);

        lsec(8'h42);
        step(1);
        chk("fl_pre", disp(), hx(D0, D0, D4, D2));
        bus.flash = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (k >= 3 && k < 6 || k == 9)
                chk("fl_blank", disp(), hx(BL, BL, BL, BL));
            else
                chk("fl_show", disp(), hx(D0, D0, D4, D2));
        end
        bus.flash = 1'b0;
        step(1);
        chk("fl_off", disp(), hx(D0, D0, D4, D2));
        bus.flash = 1'b1;
        step(1);
        chk("fl_restart", disp(), hx(D0, D0, D4, D2));
        bus.flash = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_display_core.md
# countdown_display_core

Timer datapath and display driver directly downstream of the stopwatch control state machine. It holds an MM:SS value in BCD, loads minutes and seconds from the switch value on command, and counts down at 1 Hz derived from CLOCK_50 while enabled. It drives the four seven-segment digits, including a blanking flash mode, and reports when the count reaches zero.

## Interface
- TICKS_PER_SEC, 50000000, CLOCK_50 cycles per one-second decrement
- BLINK_TICKS, 25000000, CLOCK_50 cycles per flash phase (visible or blank)

- CLOCK_50  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clock CLOCK_50
- sw_val  input  8  BCD pair from switches: [7:4] tens, [3:0] ones
- load_sec  input  1  single-cycle pulse: load seconds from sw_val
- load_min  input  1  single-cycle pulse: load minutes from sw_val
- clear  input  1  single-cycle pulse: time and prescaler to zero
- run  input  1  level: count down while high
- flash  input  1  level: blink display while high
- zero  output  1  registered, high when time is 00:00
- done  output  1  registered single-cycle pulse when a decrement reaches 00:00
- HEX0  output  7  seconds ones, active-low, bit0=a … bit6=g
- HEX1  output  7  seconds tens
- HEX2  output  7  minutes ones
- HEX3  output  7  minutes tens

## Operation
- Registers: four 4-bit BCD digits (mt, mo, st, so), prescaler of ceil(log2(TICKS_PER_SEC)) bits, blink counter, blink phase, output registers.
- Priority each cycle: clear > load_sec/load_min > run. load_sec and load_min together load both fields from the same sw_val.
- Load clamp, per nibble: seconds tens > 5 → 5; any ones > 9 → 9; minutes tens > 9 → 9. Examples: 8'h7C → 59 seconds; 8'hA3 → 93 minutes.
- A load or clear resets the prescaler to 0.
- While run is high, the prescaler counts 0 … TICKS_PER_SEC-1 and wraps. The wrap cycle is the tick.
- While run is low, the prescaler holds its value, so a pause preserves the partial second.
- On a tick with time nonzero, decrement with borrow:
  - so 0 → 9 and borrow, else so-1
  - st 0 → 5 and borrow
  - mo 0 → 9 and borrow
  - mt decrements
- On a tick with time 00:00, time holds and done stays low.
- done pulses high for one cycle only on a decrement that yields 00:00.
- zero = (all digits == 0), registered.
- Flash:
  - While flash is high, the blink counter counts 0 … BLINK_TICKS-1. On each wrap, phase toggles.
  - Phase 0 shows digits; phase 1 drives all HEX outputs to 7'h7F (blank).
  - When flash is low, the counter and phase are held at 0, so the display is visible.
  - On the rising edge of flash, the first BLINK_TICKS cycles are visible.
- Segment codes (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).

## Timing
- Reset (async assert, synchronous deassert by upstream):
  - digits 0, prescaler 0, blink 0
  - HEX0–3 = 7'h40
  - zero = 1, done = 0
- Load/clear applied at edge N → digits updated at N; HEX, zero valid at N+1.
- From run rising at edge N with prescaler 0, the first tick is at cycle N+TICKS_PER_SEC-1; digits change at that edge and HEX one edge later.
- done asserts at the same edge as zero rises from a decrement, and deasserts the next edge.
- Load coincident with a tick: load wins, no decrement, prescaler 0.
- Clear coincident with a tick that would reach zero: no done pulse.
- Reset asserted mid-count: immediate return to reset values; no done.

## Test plan
- Reset, then TICKS_PER_SEC=4: HEX3..0 = 40,40,40,40; zero=1; done=0 with run high for 20 cycles.
- load_min sw_val=8'h01, load_sec sw_val=8'h00, run → after 4 cycles display 00:59; with flash low, HEX1=12 and HEX0=10.
- Load 00:02, run → two ticks; done high exactly one cycle at the second tick, zero=1; further ticks hold 00:00 with no done.
- Clamp: load_sec 8'hFF → 59; load_min 8'hAB → 99; then decrement 99:00 → 98:59.
- Pause: run high 2 cycles, low 10, high 2 → exactly one tick total, at cycle 4 of running time; load during run resets the prescaler.
- flash high with BLINK_TICKS=3: HEX outputs visible 3 cycles, 7F 3 cycles, repeating; flash low → visible next cycle.
